// File: rtl/mm_arbiter.sv
// mm_arbiter: shares one main memory between the CPU datapath port and the
// UART loader port. Each access runs IDLE -> ACC (MEM_LAT cycles) -> ACK.
// Contention is resolved round-robin. While boot is high, only the loader
// can be granted.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   boot                     loader owns memory; CPU grants are blocked
//   cpu_req/wr/addr/wdata    CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack       CPU read data register, one-cycle completion pulse
//   cpu_stall                combinational cpu_req & ~cpu_ack
//   ldr_*                    same set for the loader port (no stall output)
//   mm_rd/mm_wr/addr/wdata   memory strobes and payload (registered)
//   mm_rdata                 memory read data
//   owner                    0 = CPU, 1 = loader; current or last grant
module mm_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_wr,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mm_rd,
  output logic          mm_wr,
  output logic [AW-1:0] mm_addr,
  output logic [DW-1:0] mm_wdata,
  input  logic [DW-1:0] mm_rdata,
  output logic          owner
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic          wr_q, wr_d;
  logic          last, last_d;

  logic          mm_rd_d, mm_wr_d, owner_d, cpu_ack_d, ldr_ack_d;
  logic [AW-1:0] mm_addr_d;
  logic [DW-1:0] mm_wdata_d, cpu_rdata_d, ldr_rdata_d;

  logic cpu_elig, ldr_elig, any_elig, pick_ldr;

  // Request eligibility and round-robin pick (1 = loader)
  assign cpu_elig = cpu_req & ~boot;
  assign ldr_elig = ldr_req;
  assign any_elig = cpu_elig | ldr_elig;
  assign pick_ldr = (cpu_elig & ldr_elig) ? ~last : ldr_elig;

  assign cpu_stall = cpu_req & ~cpu_ack;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = ACC;
      ACC:     if (cnt == '0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; registered below
  always_comb begin
    mm_rd_d     = mm_rd;
    mm_wr_d     = 1'b0;
    mm_addr_d   = mm_addr;
    mm_wdata_d  = mm_wdata;
    owner_d     = owner;
    cnt_d       = cnt;
    wr_d        = wr_q;
    last_d      = last;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata;
    ldr_rdata_d = ldr_rdata;
    case (state)
      IDLE: begin
        if (any_elig) begin
          wr_d       = pick_ldr ? ldr_wr    : cpu_wr;
          mm_addr_d  = pick_ldr ? ldr_addr  : cpu_addr;
          mm_wdata_d = pick_ldr ? ldr_wdata : cpu_wdata;
          owner_d    = pick_ldr;
          cnt_d      = CNT_INIT;
          // Write strobe is asserted for the first ACC cycle only
          mm_rd_d    = ~wr_d;
          mm_wr_d    = wr_d;
        end
      end
      ACC: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          mm_rd_d = 1'b0;
          if (!wr_q) begin
            if (owner) ldr_rdata_d = mm_rdata;
            else       cpu_rdata_d = mm_rdata;
          end
          // Ack register becomes visible in the ACK cycle
          if (owner) ldr_ack_d = 1'b1;
          else       cpu_ack_d = 1'b1;
        end
      end
      ACK: begin
        mm_rd_d = 1'b0;
        last_d  = owner;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk) begin
    if (!rst) begin
      mm_rd     <= 1'b0;
      mm_wr     <= 1'b0;
      mm_addr   <= '0;
      mm_wdata  <= '0;
      owner     <= 1'b0;
      cnt       <= '0;
      wr_q      <= 1'b0;
      last      <= 1'b1;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      mm_rd     <= mm_rd_d;
      mm_wr     <= mm_wr_d;
      mm_addr   <= mm_addr_d;
      mm_wdata  <= mm_wdata_d;
      owner     <= owner_d;
      cnt       <= cnt_d;
      wr_q      <= wr_d;
      last      <= last_d;
      cpu_ack   <= cpu_ack_d;
      ldr_ack   <= ldr_ack_d;
      cpu_rdata <= cpu_rdata_d;
      ldr_rdata <= ldr_rdata_d;
    end
  end

endmodule

// File: tb/tb_mm_arbiter.sv
// Bench for mm_arbiter: four instances (MEM_LAT = 2, 3, 1, 4) share one set of
// inputs; each scenario checks the instance whose latency it targets.
module tb_mm_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned ND = 4;
  localparam logic [31:0] RD_VAL  = 32'hDEAD_BEEF;
  localparam logic [31:0] CPU_A   = 32'h0000_0010;
  localparam logic [31:0] LDR_A   = 32'h0000_0040;
  localparam logic [31:0] LDR_WD  = 32'h1234_5678;
  localparam logic [31:0] CPU_WD  = 32'hA5A5_A5A5;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot;
  logic          cpu_req, cpu_wr, ldr_req, ldr_wr;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata, mm_rdata;

  logic [DW-1:0] cpu_rdata [ND];
  logic [DW-1:0] ldr_rdata [ND];
  logic [AW-1:0] mm_addr   [ND];
  logic [DW-1:0] mm_wdata  [ND];
  logic          cpu_ack   [ND];
  logic          ldr_ack   [ND];
  logic          cpu_stall [ND];
  logic          mm_rd     [ND];
  logic          mm_wr     [ND];
  logic          owner     [ND];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mm_arbiter #(
      .AW(AW), .DW(DW),
      .MEM_LAT((g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 4)
    ) u_dut (
      .clk(clk), .rst(rst), .boot(boot),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]),
      .cpu_stall(cpu_stall[g]),
      .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr),
      .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata[g]), .ldr_ack(ldr_ack[g]),
      .mm_rd(mm_rd[g]), .mm_wr(mm_wr[g]), .mm_addr(mm_addr[g]),
      .mm_wdata(mm_wdata[g]), .mm_rdata(mm_rdata), .owner(owner[g])
    );
  end

  typedef struct {
    logic        rst_n, boot, cpu_req, cpu_wr, ldr_req, ldr_wr;
    int          d;
    logic        e_rd, e_wr, e_cack, e_lack, e_owner, e_stall;
    logic [31:0] e_crd, e_lrd, e_addr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (dut%0d @%0t): got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input int d);
    chk({tag, " mm_rd"},     d, 32'(mm_rd[d]),   32'd0);
    chk({tag, " mm_wr"},     d, 32'(mm_wr[d]),   32'd0);
    chk({tag, " mm_addr"},   d, mm_addr[d],      32'd0);
    chk({tag, " mm_wdata"},  d, mm_wdata[d],     32'd0);
    chk({tag, " cpu_rdata"}, d, cpu_rdata[d],    32'd0);
    chk({tag, " ldr_rdata"}, d, ldr_rdata[d],    32'd0);
    chk({tag, " cpu_ack"},   d, 32'(cpu_ack[d]), 32'd0);
    chk({tag, " ldr_ack"},   d, 32'(ldr_ack[d]), 32'd0);
    chk({tag, " owner"},     d, 32'(owner[d]),   32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; boot = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
    cpu_wr = 1'b0; ldr_wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // rst_n boot creq cwr lreq lwr d | rd wr cack lack own stall | crd lrd addr
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0, 32'd0,32'd0};
    vecs[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 32'd0, 32'd0,CPU_A};
    vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 32'd0, 32'd0,CPU_A};
    vecs[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, RD_VAL,32'd0,32'd0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, RD_VAL,32'd0,32'd0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, RD_VAL,32'd0,32'd0};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, RD_VAL,32'd0,32'd0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, RD_VAL,32'd0,LDR_A};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, RD_VAL,32'd0,32'd0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, RD_VAL,32'd0,32'd0};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, RD_VAL,32'd0,32'd0};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, RD_VAL,32'd0,32'd0};

    // Reset held for two cycles under random inputs
    rst = 1'b0;
    mm_rdata = RD_VAL;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      boot = 1'($urandom); cpu_req = 1'($urandom); ldr_req = 1'($urandom);
      cpu_wr = 1'($urandom); ldr_wr = 1'($urandom);
      cpu_addr = $urandom; ldr_addr = $urandom;
      cpu_wdata = $urandom; ldr_wdata = $urandom;
      step();
    end
    for (int d = 0; d < ND; d++) chk_zero("reset", d);

    // Release with both requesting: CPU wins the first tie
    @(negedge clk);
    rst = 1'b1; boot = 1'b0; cpu_req = 1'b1; ldr_req = 1'b1;
    cpu_wr = 1'b0; ldr_wr = 1'b0;
    cpu_addr = CPU_A; ldr_addr = LDR_A; cpu_wdata = CPU_WD; ldr_wdata = LDR_WD;
    step();
    chk("first_tie owner", 0, 32'(owner[0]), 32'd0);
    chk("first_tie mm_rd", 0, 32'(mm_rd[0]), 32'd1);
    chk("first_tie addr",  0, mm_addr[0], CPU_A);

    // Table: CPU read (MEM_LAT=2) then loader write (MEM_LAT=3)
    for (int i = 0; i < 12; i++) begin
      int d;
      @(negedge clk);
      rst = vecs[i].rst_n; boot = vecs[i].boot;
      cpu_req = vecs[i].cpu_req; cpu_wr = vecs[i].cpu_wr;
      ldr_req = vecs[i].ldr_req; ldr_wr = vecs[i].ldr_wr;
      step();
      d = vecs[i].d;
      chk($sformatf("v%0d mm_rd", i),     d, 32'(mm_rd[d]),     32'(vecs[i].e_rd));
      chk($sformatf("v%0d mm_wr", i),     d, 32'(mm_wr[d]),     32'(vecs[i].e_wr));
      chk($sformatf("v%0d cpu_ack", i),   d, 32'(cpu_ack[d]),   32'(vecs[i].e_cack));
      chk($sformatf("v%0d ldr_ack", i),   d, 32'(ldr_ack[d]),   32'(vecs[i].e_lack));
      chk($sformatf("v%0d owner", i),     d, 32'(owner[d]),     32'(vecs[i].e_owner));
      chk($sformatf("v%0d cpu_stall", i), d, 32'(cpu_stall[d]), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d cpu_rdata", i), d, cpu_rdata[d],      vecs[i].e_crd);
      chk($sformatf("v%0d ldr_rdata", i), d, ldr_rdata[d],      vecs[i].e_lrd);
      if (vecs[i].e_rd || vecs[i].e_wr)
        chk($sformatf("v%0d mm_addr", i), d, mm_addr[d], vecs[i].e_addr);
      if (vecs[i].e_wr)
        chk($sformatf("v%0d mm_wdata", i), d, mm_wdata[d], LDR_WD);
    end

    // Contention, MEM_LAT=1: acks alternate CPU, LDR at 3-cycle spacing
    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cpu_req = 1'b1; ldr_req = 1'b1;
      step();
      chk($sformatf("cont%0d cpu_ack", k), 2, 32'(cpu_ack[2]), 32'((k % 6) == 1));
      chk($sformatf("cont%0d ldr_ack", k), 2, 32'(ldr_ack[2]), 32'((k % 6) == 4));
      chk($sformatf("cont%0d owner", k),   2, 32'(owner[2]),   32'((k % 6) >= 3));
    end

    // Boot: only the loader is served; CPU stays stalled
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      boot = 1'b1; cpu_req = 1'b1; ldr_req = 1'b1;
      step();
      chk($sformatf("boot%0d cpu_ack", k),   2, 32'(cpu_ack[2]),   32'd0);
      chk($sformatf("boot%0d cpu_stall", k), 2, 32'(cpu_stall[2]), 32'd1);
      chk($sformatf("boot%0d ldr_ack", k),   2, 32'(ldr_ack[2]),   32'((k % 3) == 1));
    end
    @(negedge clk);
    boot = 1'b0;
    step();
    chk("boot_exit owner", 2, 32'(owner[2]), 32'd0);
    chk("boot_exit mm_rd", 2, 32'(mm_rd[2]), 32'd1);
    step();
    chk("boot_exit cpu_ack", 2, 32'(cpu_ack[2]), 32'd1);

    // Reset in the 2nd ACC cycle of a MEM_LAT=4 read aborts it silently
    do_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0;
    step();
    chk("abort acc1 mm_rd", 3, 32'(mm_rd[3]), 32'd1);
    step();
    chk("abort acc2 mm_rd", 3, 32'(mm_rd[3]), 32'd1);
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0;
    step();
    chk_zero("abort", 3);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("abort_after%0d cpu_ack", k), 3, 32'(cpu_ack[3]), 32'd0);
      chk($sformatf("abort_after%0d mm_rd", k),   3, 32'(mm_rd[3]),   32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
